// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle for pipe_hazard_ctrl: ID-stage inputs, hazard and flush controls,
// forwarding selects and event counters. The controller uses the slave view.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic [31:0]      id_instr;
    logic             id_valid;
    logic             id_jump;
    logic             exe_branch_taken;
    logic             stall;
    logic             flush_if;
    logic             flush_id;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic [1:0]       state;

    modport master (
        output id_instr, id_valid, id_jump, exe_branch_taken,
        input  stall, flush_if, flush_id, fwd_a, fwd_b, stall_count, flush_count, state
    );

    modport slave (
        input  id_instr, id_valid, id_jump, exe_branch_taken,
        output stall, flush_if, flush_id, fwd_a, fwd_b, stall_count, flush_count, state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage MIPS hazard controller: load-use/RAW stall, branch/jump flush, optional forwarding.
// Define PIPE_HAZARD_FORWARD_EN to enable EX/MEM and MEM/WB forwarding selects.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StStall = 2'b01,
        StFlush = 2'b10
    } state_e;

    state_e state_q, state_d;

    logic [5:0] op;
    logic [4:0] rs, rt, rd, dst;
    logic       use_rs, use_rt, is_load;
    logic       rs_live, rt_live;
    logic       ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic       hazard, stall, flush, ld_ex;

    // Scoreboard entries for instructions in EX, MEM and WB.
    logic       ex_valid_q, mem_valid_q, wb_valid_q;
    logic [4:0] ex_dst_q, mem_dst_q, wb_dst_q;
    logic       ex_load_q, mem_load_q, wb_load_q;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    assign op = bus.id_instr[31:26];
    assign rs = bus.id_instr[25:21];
    assign rt = bus.id_instr[20:16];
    assign rd = bus.id_instr[15:11];

    always_comb begin
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        is_load = 1'b0;
        dst     = 5'd0;
        case (op)
            6'h00: begin use_rs = 1'b1; use_rt = 1'b1; dst = rd; end
            6'h23: begin use_rs = 1'b1; dst = rt; is_load = 1'b1; end
            6'h08: begin use_rs = 1'b1; dst = rt; end
            6'h2B, 6'h04, 6'h05: begin use_rs = 1'b1; use_rt = 1'b1; end
            default: ;
        endcase
    end

    // $0 is never a hazard source; entries only become valid with a nonzero dst.
    assign rs_live    = bus.id_valid & use_rs & (rs != 5'd0);
    assign rt_live    = bus.id_valid & use_rt & (rt != 5'd0);
    assign ex_hit_rs  = rs_live & ex_valid_q & (ex_dst_q == rs);
    assign ex_hit_rt  = rt_live & ex_valid_q & (ex_dst_q == rt);
    assign mem_hit_rs = rs_live & mem_valid_q & (mem_dst_q == rs);
    assign mem_hit_rt = rt_live & mem_valid_q & (mem_dst_q == rt);

`ifdef PIPE_HAZARD_FORWARD_EN
    assign hazard = ex_load_q & (ex_hit_rs | ex_hit_rt);
`else
    assign hazard = ex_hit_rs | ex_hit_rt | mem_hit_rs | mem_hit_rt;
`endif

    // A taken branch overrides any hazard; detection is muted for the cycle after a flush.
    assign flush = rst & bus.exe_branch_taken;
    assign stall = rst & hazard & ~bus.exe_branch_taken & (state_q != StFlush);
    assign ld_ex = bus.id_valid & ~stall & ~flush;

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.exe_branch_taken) begin
            state_d = StFlush;
        end else begin
            case (state_q)
                StRun:   if (stall) state_d = StStall;
                StStall: if (!stall) state_d = StRun;
                StFlush: state_d = StRun;
                default: state_d = StRun;
            endcase
        end
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StRun;
            ex_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            ex_dst_q    <= 5'd0;
            mem_dst_q   <= 5'd0;
            wb_dst_q    <= 5'd0;
            ex_load_q   <= 1'b0;
            mem_load_q  <= 1'b0;
            wb_load_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_valid_q  <= ld_ex & (dst != 5'd0);
            ex_dst_q    <= dst;
            ex_load_q   <= ld_ex & is_load;
            mem_valid_q <= ex_valid_q;
            mem_dst_q   <= ex_dst_q;
            mem_load_q  <= ex_load_q;
            wb_valid_q  <= mem_valid_q;
            wb_dst_q    <= mem_dst_q;
            wb_load_q   <= mem_load_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef PIPE_HAZARD_FORWARD_EN
    logic [1:0] fwd_a_q, fwd_b_q;

    // Newest producer wins: EX/MEM ALU result over MEM/WB data.
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic ex_load,
                                           input logic mem_hit);
        if (ex_hit && !ex_load) return 2'b10;
        if (mem_hit) return 2'b01;
        return 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            fwd_a_q <= ld_ex ? fwd_sel(ex_hit_rs, ex_load_q, mem_hit_rs) : 2'b00;
            fwd_b_q <= ld_ex ? fwd_sel(ex_hit_rt, ex_load_q, mem_hit_rt) : 2'b00;
        end
    end

    assign bus.fwd_a = fwd_a_q;
    assign bus.fwd_b = fwd_b_q;
`else
    assign bus.fwd_a = 2'b00;
    assign bus.fwd_b = 2'b00;
`endif

    // WB entry and low instruction bits are tracked but not consulted.
    logic unused_sb;
    assign unused_sb = ^{wb_valid_q, wb_dst_q, wb_load_q, mem_load_q, ex_load_q,
                         bus.id_instr[10:0]};

    assign bus.stall       = stall;
    assign bus.flush_if    = rst & (bus.exe_branch_taken | (bus.id_jump & ~stall));
    assign bus.flush_id    = flush;
    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations queued on stimulus, popped on observation.
module tb_pipe_hazard_ctrl;
    localparam int unsigned CW   = 4;
    localparam int          MAXC = (1 << CW) - 1;
`ifdef PIPE_HAZARD_FORWARD_EN
    localparam int NS_LW  = 1;
    localparam int NS_ADD = 0;
`else
    localparam int NS_LW  = 2;
    localparam int NS_ADD = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();
    pipe_hazard_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          total = 0;
    int          bad   = 0;
    int          exp_sc = 0;
    int          exp_fc = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] r_ins(input int s, input int t, input int d);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, 6'h20};
    endfunction
    function automatic logic [31:0] i_ins(input int op, input int s, input int t, input int imm);
        return {6'(op), 5'(s), 5'(t), 16'(imm)};
    endfunction
    function automatic int sat(input int x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    // $t0=8 $t1=9 $t2=10 $s0=16 $s1=17
    logic [31:0] add1, add2, lw0, addi0, addz, jmp;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic j, input logic b);
        bus.id_instr         = ins;
        bus.id_valid         = v;
        bus.id_jump          = j;
        bus.exe_branch_taken = b;
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [31:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
        push_exp(tag, e);
        pop_cmp(obs);
    endtask

    task automatic hazard_pair();
        drive(lw0, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(add2, 1'b1, 1'b0, 1'b0);
        repeat (NS_LW) cyc();
        exp_sc = sat(exp_sc + NS_LW);
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("sat_count", 32'(bus.stall_count), exp_sc);
    endtask

    initial begin
        add1  = r_ins(16, 17, 8);
        add2  = r_ins(8, 10, 9);
        lw0   = i_ins(8'h23, 16, 8, 0);
        addi0 = i_ins(8'h08, 16, 0, 5);
        addz  = r_ins(0, 10, 9);
        jmp   = {6'h02, 26'h0};

        // Reset: controls held low even with a taken branch driven.
        drive(32'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_flush_if", 32'(bus.flush_if), 0);
        chk("rst_flush_id", 32'(bus.flush_id), 0);
        cyc();
        cyc();
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_scnt", 32'(bus.stall_count), 0);
        chk("rst_fcnt", 32'(bus.flush_count), 0);
        chk("rst_fwd_a", 32'(bus.fwd_a), 0);
        chk("rst_fwd_b", 32'(bus.fwd_b), 0);
        rst = 1'b1;
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        cyc();

        // ALU RAW dependency.
        drive(add1, 1'b1, 1'b0, 1'b0);
        chk("add_first_stall", 32'(bus.stall), 0);
        cyc();
        drive(add2, 1'b1, 1'b0, 1'b0);
`ifdef PIPE_HAZARD_FORWARD_EN
        chk("add_fwd_nostall", 32'(bus.stall), 0);
        cyc();
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        chk("add_fwd_a", 32'(bus.fwd_a), 32'h2);
        chk("add_fwd_b", 32'(bus.fwd_b), 0);
        chk("add_scnt", 32'(bus.stall_count), exp_sc);
        cyc();
`else
        chk("add_stall1", 32'(bus.stall), 1);
        chk("add_state1", 32'(bus.state), 0);
        cyc();
        chk("add_stall2", 32'(bus.stall), 1);
        chk("add_state2", 32'(bus.state), 1);
        cyc();
        exp_sc += NS_ADD;
        chk("add_stall3", 32'(bus.stall), 0);
        chk("add_state3", 32'(bus.state), 1);
        chk("add_scnt", 32'(bus.stall_count), exp_sc);
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("add_state4", 32'(bus.state), 0);
`endif

        // Load-use.
        drive(lw0, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(add2, 1'b1, 1'b0, 1'b0);
        chk("lw_stall1", 32'(bus.stall), 1);
        cyc();
`ifdef PIPE_HAZARD_FORWARD_EN
        chk("lw_stall2", 32'(bus.stall), 0);
        chk("lw_state", 32'(bus.state), 1);
        exp_sc += NS_LW;
        chk("lw_scnt", 32'(bus.stall_count), exp_sc);
        cyc();
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        chk("lw_fwd_a", 32'(bus.fwd_a), 32'h1);
        cyc();
`else
        chk("lw_stall2", 32'(bus.stall), 1);
        cyc();
        chk("lw_stall3", 32'(bus.stall), 0);
        exp_sc += NS_LW;
        chk("lw_scnt", 32'(bus.stall_count), exp_sc);
        cyc();
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        chk("lw_fwd_a", 32'(bus.fwd_a), 0);
        cyc();
`endif
        chk("lw_state_end", 32'(bus.state), 0);

        // Register $0 never hazards.
        drive(addi0, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(addz, 1'b1, 1'b0, 1'b0);
        chk("zero_stall", 32'(bus.stall), 0);
        cyc();
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        chk("zero_fwd_a", 32'(bus.fwd_a), 0);
        chk("zero_fwd_b", 32'(bus.fwd_b), 0);
        cyc();

        // Taken branch against a live hazard.
        drive(lw0, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(add2, 1'b1, 1'b0, 1'b1);
        chk("br_stall", 32'(bus.stall), 0);
        chk("br_flush_if", 32'(bus.flush_if), 1);
        chk("br_flush_id", 32'(bus.flush_id), 1);
        cyc();
        exp_fc += 1;
        drive(add2, 1'b1, 1'b0, 1'b0);
        chk("br_state_flush", 32'(bus.state), 2);
        chk("br_muted_stall", 32'(bus.stall), 0);
        chk("br_flush_id_off", 32'(bus.flush_id), 0);
        chk("br_fcnt", 32'(bus.flush_count), exp_fc);
        cyc();
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        chk("br_state_run", 32'(bus.state), 0);
        cyc();

        // Jump: immediate when free, deferred while stalled.
        drive(jmp, 1'b1, 1'b1, 1'b0);
        chk("j_flush_if", 32'(bus.flush_if), 1);
        chk("j_flush_id", 32'(bus.flush_id), 0);
        cyc();
        drive(lw0, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(add2, 1'b1, 1'b1, 1'b0);
        chk("j_stalled_flush_if", 32'(bus.flush_if), 0);
        repeat (NS_LW) cyc();
        exp_sc += NS_LW;
        chk("j_released_stall", 32'(bus.stall), 0);
        chk("j_released_flush_if", 32'(bus.flush_if), 1);
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("j_scnt", 32'(bus.stall_count), exp_sc);

        // Reset in the middle of a stall.
        drive(lw0, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(add2, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("rs_mid_state", 32'(bus.state), 1);
        rst = 1'b0;
        drive(add2, 1'b1, 1'b0, 1'b0);
        chk("rs_stall_low", 32'(bus.stall), 0);
        cyc();
        exp_sc = 0;
        exp_fc = 0;
        chk("rs_state", 32'(bus.state), 0);
        chk("rs_scnt", 32'(bus.stall_count), exp_sc);
        chk("rs_fcnt", 32'(bus.flush_count), exp_fc);
        rst = 1'b1;
        drive(add2, 1'b1, 1'b0, 1'b0);
        chk("rs_no_residual", 32'(bus.stall), 0);
        cyc();
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        cyc();

        // Saturation of the stall counter.
        for (int i = 0; i < 16; i++) hazard_pair();
        drive(lw0, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(add2, 1'b1, 1'b0, 1'b0);
        chk("sat_stall", 32'(bus.stall), 1);
        cyc();
        chk("sat_hold", 32'(bus.stall_count), MAXC);
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the event counters.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port id_instr  input  32  MIPS instruction held in the IF/ID register.
REQ-005 SHALL have port id_valid  input  1  id_instr is a real instruction, not a bubble.
REQ-006 SHALL have port id_jump  input  1  ID-stage j decoded.
REQ-007 SHALL have port exe_branch_taken  input  1  EXE-stage beq/bne resolved taken.
REQ-008 SHALL have port stall  output  1  hold PC and IF/ID; inject bubble into ID/EXE.
REQ-009 SHALL have port flush_if  output  1  squash IF/ID contents.
REQ-010 SHALL have port flush_id  output  1  squash ID/EXE contents.
REQ-011 SHALL have ports fwd_a, fwd_b  output  2 each  operand select for the instruction in EXE: 00 regfile, 10 EX/MEM ALU result, 01 MEM/WB data.
REQ-012 SHALL have ports stall_count, flush_count  output  CNT_W each  saturating event counters.
REQ-013 SHALL have port state  output  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH.

Function
REQ-014 SHALL decode id_instr: R-type (op 0x00) dst=rd, src rs,rt; lw (0x23) dst=rt, src rs, load; addi (0x08) dst=rt, src rs; sw (0x2B), beq (0x04), bne (0x05) src rs,rt, no dst; j (0x02) no src/dst; dst=0 means no write.
REQ-015 SHALL keep a 3-entry scoreboard EX/MEM/WB of {valid, dst[4:0], load}, shifting EX->MEM->WB every cycle.
REQ-016 SHALL load EX entry from the decoded ID instruction when id_valid and not stall and not flush_id; otherwise EX entry becomes invalid.
REQ-017 SHALL treat register $0 as never hazardous.
REQ-018 Without forwarding, SHALL assert stall combinationally while any ID source matches a valid dst in EX or MEM; WB matches never stall (regfile writes before read).
REQ-019 With forwarding, SHALL assert stall only when an ID source matches the EX entry with load=1 (exactly one bubble).
REQ-020 With forwarding, SHALL register fwd_a (rs) / fwd_b (rt) alongside the EX entry: match EX non-load -> 10, else match MEM -> 01, else 00; newest producer wins.
REQ-021 exe_branch_taken SHALL assert flush_if and flush_id in the same cycle and force stall=0 (flush wins over hazard).
REQ-022 id_jump SHALL assert flush_if only when stall=0; a stalled jump flushes when released.
REQ-023 FSM: RUN->STALL when stall; STALL->RUN when hazard clears; any->FLUSH on exe_branch_taken; FLUSH->RUN next cycle, hazard detection suppressed in FLUSH.
REQ-024 stall_count SHALL increment each cycle stall=1, flush_count each cycle flush_id=1; both hold at all-ones.

Reset
REQ-025 When rst=0 at a rising edge, SHALL invalidate all scoreboard entries, set state RUN, fwd_a=fwd_b=00, counters 0; stall/flush_if/flush_id SHALL be 0 while rst=0.
REQ-026 Reset mid-STALL or mid-FLUSH SHALL abandon the operation with no residual stall afterwards.

Configuration
REQ-027 Macro PIPE_HAZARD_FORWARD_EN: defined -> REQ-019/020 behaviour; undefined -> REQ-018 behaviour and fwd_a/fwd_b tied to 00.

Verification
REQ-028 add $t0,$s0,$s1 then add $t1,$t0,$t2: macro off -> stall 2 cycles, stall_count=2; macro on -> no stall, fwd_a=10 in EXE.
REQ-029 Macro on: lw $t0,0($s0) then add $t1,$t0,$t2 -> stall exactly 1 cycle, then fwd_a=01.
REQ-030 exe_branch_taken=1 while ID hazard present -> flush_if=flush_id=1, stall=0, state FLUSH then RUN, flush_count+1.
REQ-031 addi $0,$s0,5 then add $t1,$0,$t2 -> no stall, fwd_a=00.
REQ-032 rst=0 during STALL -> next edge state=00, stall=0, counters 0.
REQ-033 stall_count preset via sustained hazards to all-ones -> stays all-ones on further stalls.
